// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA channel request arbiter.
package dma_priority_arbiter_pkg;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_W = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HOLD  = 2'd1,
        ARB_GRANT = 2'd2
    } arb_state_t;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    localparam int unsigned CMD_DISABLE    = 2;
    localparam int unsigned CMD_ROTATE     = 4;
    localparam int unsigned CMD_DREQ_SENSE = 6;
    localparam int unsigned CMD_DACK_SENSE = 7;

    function automatic logic [NCH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        ch_onehot     = '0;
        ch_onehot[ch] = 1'b1;
    endfunction

endpackage

// File: rtl/dma_priority_arbiter_encoder.sv
// Circular priority search: first asserted request at or after start_ptr_i.
module dma_priority_encoder
    import dma_priority_arbiter_pkg::*;
(
    input  logic [NCH-1:0]  req_i,
    input  logic [CH_W-1:0] start_ptr_i,
    output logic            hit_c_o,
    output logic [CH_W-1:0] winner_c_o
);

    always_comb begin
        logic [CH_W-1:0] idx;
        hit_c_o    = 1'b0;
        winner_c_o = '0;
        idx        = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = start_ptr_i + CH_W'(k);
            if (!hit_c_o && req_i[idx]) begin
                hit_c_o    = 1'b1;
                winner_c_o = idx;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA channel request arbiter with HRQ/HLDA handshake.
// Optional rotating priority is built when DMA_ROTATING_PRIORITY_EN is defined.
module dma_priority_arbiter
    import dma_priority_arbiter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NCH-1:0]   dreq_i,
    input  logic             hlda_i,
    input  logic [7:0]       command_reg_i,
    input  logic [NCH-1:0]   mask_reg_i,
    input  logic [NCH-1:0]   request_reg_i,
    input  logic [NCH*8-1:0] mode_reg_i,
    input  logic             valid_dack_i,
    input  logic             xfer_done_i,
    input  logic             eop_i,
    output logic             hrq_o,
    output logic [NCH-1:0]   dack_c_o,
    output logic [NCH-1:0]   valid_dreq_o,
    output logic [CH_W-1:0]  active_ch_o
);

    arb_state_t      state_q, state_d;
    logic [NCH-1:0]  sync_dreq_q;
    logic [NCH-1:0]  req_c;
    logic [CH_W-1:0] grant_q, grant_d;
    logic            eop_pend_q, eop_pend_d;
    logic            hrq_d;
    logic [NCH-1:0]  valid_dreq_d;
    logic [CH_W-1:0] start_ptr;
    logic            hit;
    logic [CH_W-1:0] winner;
    logic [1:0]      cur_mode;
    logic            eop_eff;
    logic            release_c;
    logic            unused_cfg;

    assign unused_cfg = ^{command_reg_i, mode_reg_i};

    // Sense-corrected DREQ is registered once before use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_dreq_q <= '0;
        else         sync_dreq_q <= dreq_i ^ {NCH{command_reg_i[CMD_DREQ_SENSE]}};
    end

    assign req_c   = (sync_dreq_q & ~mask_reg_i) | request_reg_i;
    assign eop_eff = eop_i | eop_pend_q;

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [CH_W-1:0] rot_ptr_q, rot_ptr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rot_ptr_q <= '0;
        else         rot_ptr_q <= rot_ptr_d;
    end

    always_comb begin
        rot_ptr_d = rot_ptr_q;
        if (release_c) rot_ptr_d = grant_q + CH_W'(1);
    end

    assign start_ptr = command_reg_i[CMD_ROTATE] ? rot_ptr_q : '0;
`else
    assign start_ptr = '0;
`endif

    dma_priority_encoder u_enc (
        .req_i       (req_c),
        .start_ptr_i (start_ptr),
        .hit_c_o     (hit),
        .winner_c_o  (winner)
    );

    always_comb begin
        cur_mode = MODE_SINGLE;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_q == CH_W'(i)) cur_mode = mode_reg_i[i*8+6 +: 2];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            eop_pend_q   <= 1'b0;
            hrq_o        <= 1'b0;
            valid_dreq_o <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            eop_pend_q   <= eop_pend_d;
            hrq_o        <= hrq_d;
            valid_dreq_o <= valid_dreq_d;
        end
    end

    // Next-state: grant frozen from HOLD until release or HLDA abort.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        eop_pend_d   = eop_pend_q;
        release_c    = 1'b0;
        hrq_d        = 1'b0;
        valid_dreq_d = '0;
        case (state_q)
            ARB_IDLE: begin
                if (hit && !command_reg_i[CMD_DISABLE]) begin
                    grant_d = winner;
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (hlda_i) state_d = ARB_GRANT;
                else if (cur_mode == MODE_DEMAND && !req_c[grant_q]) state_d = ARB_IDLE;
            end
            ARB_GRANT: begin
                if (!hlda_i) begin
                    state_d = ARB_IDLE;
                end else begin
                    if (eop_i) eop_pend_d = 1'b1;
                    if (xfer_done_i) begin
                        case (cur_mode)
                            MODE_BLOCK:  release_c = eop_eff;
                            MODE_DEMAND: release_c = eop_eff || !req_c[grant_q];
                            default:     release_c = 1'b1;
                        endcase
                    end
                    if (release_c) state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (state_d != ARB_GRANT) eop_pend_d = 1'b0;
        hrq_d = (state_d != ARB_IDLE);
        if (hrq_d) valid_dreq_d = ch_onehot(grant_d);
    end

    assign active_ch_o = grant_q;

    // DACK polarity: XOR with the inactive level turns the granted bit active.
    assign dack_c_o = {NCH{~command_reg_i[CMD_DACK_SENSE]}}
                    ^ (valid_dreq_o & {NCH{valid_dack_i && state_q == ARB_GRANT}});

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter.
module tb_dma_priority_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  dreq_i;
    logic        hlda_i;
    logic [7:0]  command_reg_i;
    logic [3:0]  mask_reg_i;
    logic [3:0]  request_reg_i;
    logic [31:0] mode_reg_i;
    logic        valid_dack_i;
    logic        xfer_done_i;
    logic        eop_i;
    logic        hrq_o;
    logic [3:0]  dack_c_o;
    logic [3:0]  valid_dreq_o;
    logic [1:0]  active_ch_o;

    int total = 0;
    int bad   = 0;

    dma_priority_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .dreq_i        (dreq_i),
        .hlda_i        (hlda_i),
        .command_reg_i (command_reg_i),
        .mask_reg_i    (mask_reg_i),
        .request_reg_i (request_reg_i),
        .mode_reg_i    (mode_reg_i),
        .valid_dack_i  (valid_dack_i),
        .xfer_done_i   (xfer_done_i),
        .eop_i         (eop_i),
        .hrq_o         (hrq_o),
        .dack_c_o      (dack_c_o),
        .valid_dreq_o  (valid_dreq_o),
        .active_ch_o   (active_ch_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clear_inputs;
        dreq_i = '0; hlda_i = 0; command_reg_i = '0; mask_reg_i = '0;
        request_reg_i = '0; mode_reg_i = {4{8'h40}}; valid_dack_i = 0;
        xfer_done_i = 0; eop_i = 0;
    endtask

    task automatic do_reset;
        rst_ni = 0;
        tick();
        rst_ni = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_ni = 0;
        tick(2);
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL reset_hrq got=%b exp=0", hrq_o); end
        total++; if (valid_dreq_o !== 4'h0) begin bad++; $display("FAIL reset_valid got=%h exp=0", valid_dreq_o); end
        total++; if (active_ch_o !== 2'd0) begin bad++; $display("FAIL reset_active got=%0d exp=0", active_ch_o); end
        total++; if (dack_c_o !== 4'hF) begin bad++; $display("FAIL reset_dack_lo got=%h exp=f", dack_c_o); end
        command_reg_i = 8'h80; #1;
        total++; if (dack_c_o !== 4'h0) begin bad++; $display("FAIL reset_dack_hi got=%h exp=0", dack_c_o); end
        command_reg_i = 8'h00;
        rst_ni = 1;
    endtask

    task automatic test_fixed;
        clear_inputs(); do_reset();
        dreq_i = 4'b1010;
        tick();
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL fixed_hrq_early got=%b exp=0", hrq_o); end
        tick();
        total++; if (hrq_o !== 1'b1) begin bad++; $display("FAIL fixed_hrq got=%b exp=1", hrq_o); end
        total++; if (valid_dreq_o !== 4'b0010) begin bad++; $display("FAIL fixed_valid got=%b exp=0010", valid_dreq_o); end
        hlda_i = 1;
        tick();
        total++; if (dack_c_o !== 4'hF) begin bad++; $display("FAIL fixed_dack_idle got=%b exp=1111", dack_c_o); end
        valid_dack_i = 1; #1;
        total++; if (dack_c_o !== 4'b1101) begin bad++; $display("FAIL fixed_dack got=%b exp=1101", dack_c_o); end
        total++; if (active_ch_o !== 2'd1) begin bad++; $display("FAIL fixed_active got=%0d exp=1", active_ch_o); end
        dreq_i = 0; valid_dack_i = 0;
        tick();
        xfer_done_i = 1;
        tick();
        xfer_done_i = 0;
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL fixed_release got=%b exp=0", hrq_o); end
        tick();
        total++; if (valid_dreq_o !== 4'h0) begin bad++; $display("FAIL fixed_idle_valid got=%b exp=0", valid_dreq_o); end
    endtask

    task automatic test_rotating;
        logic [1:0] exp_ch [5];
`ifdef DMA_ROTATING_PRIORITY_EN
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        exp_ch = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        clear_inputs(); do_reset();
        command_reg_i = 8'h10; dreq_i = 4'hF; hlda_i = 1;
        tick(2);
        for (int r = 0; r < 5; r++) begin
            tick();
            total++; if (active_ch_o !== exp_ch[r]) begin bad++; $display("FAIL rot_ch%0d got=%0d exp=%0d", r, active_ch_o, exp_ch[r]); end
            xfer_done_i = 1;
            tick();
            xfer_done_i = 0;
            total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL rot_hrq_low%0d got=%b exp=0", r, hrq_o); end
            tick();
        end
    endtask

    task automatic test_mask_swreq;
        clear_inputs(); do_reset();
        mask_reg_i = 4'b0001; dreq_i = 4'b0001;
        tick(3);
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL mask_hrq got=%b exp=0", hrq_o); end
        request_reg_i = 4'b0001;
        tick();
        total++; if (valid_dreq_o !== 4'b0001) begin bad++; $display("FAIL swreq_valid got=%b exp=0001", valid_dreq_o); end
        hlda_i = 1;
        tick();
        valid_dack_i = 1; #1;
        total++; if (dack_c_o !== 4'b1110) begin bad++; $display("FAIL swreq_dack got=%b exp=1110", dack_c_o); end
    endtask

    task automatic test_block;
        clear_inputs(); do_reset();
        mode_reg_i = {8'h40, 8'h80, 8'h40, 8'h40};
        dreq_i = 4'b0100; hlda_i = 1;
        tick(3);
        xfer_done_i = 1; tick(); xfer_done_i = 0;
        total++; if (hrq_o !== 1'b1 || valid_dreq_o !== 4'b0100) begin bad++; $display("FAIL block_keep got=%b/%b exp=1/0100", hrq_o, valid_dreq_o); end
        eop_i = 1; tick(); eop_i = 0; tick();
        total++; if (hrq_o !== 1'b1) begin bad++; $display("FAIL block_eop_pend got=%b exp=1", hrq_o); end
        xfer_done_i = 1; tick(); xfer_done_i = 0;
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL block_pend_release got=%b exp=0", hrq_o); end
        tick(2);
        total++; if (valid_dreq_o !== 4'b0100) begin bad++; $display("FAIL block_regrant got=%b exp=0100", valid_dreq_o); end
        xfer_done_i = 1; eop_i = 1; tick(); xfer_done_i = 0; eop_i = 0;
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL block_eop_release got=%b exp=0", hrq_o); end
    endtask

    task automatic test_demand;
        clear_inputs(); do_reset();
        mode_reg_i = {8'h40, 8'h00, 8'h40, 8'h40};
        dreq_i = 4'b0100; hlda_i = 1;
        tick(3);
        xfer_done_i = 1; tick(); xfer_done_i = 0;
        total++; if (hrq_o !== 1'b1) begin bad++; $display("FAIL demand_keep got=%b exp=1", hrq_o); end
        dreq_i = 0; tick();
        total++; if (hrq_o !== 1'b1) begin bad++; $display("FAIL demand_wait_xfer got=%b exp=1", hrq_o); end
        xfer_done_i = 1; tick(); xfer_done_i = 0;
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL demand_release got=%b exp=0", hrq_o); end
        // Request withdrawn while waiting for HLDA.
        do_reset(); hlda_i = 0; dreq_i = 4'b0100;
        tick(2);
        dreq_i = 0;
        tick(2);
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL demand_hold_drop got=%b exp=0", hrq_o); end
    endtask

    task automatic test_abort_reset;
        clear_inputs(); do_reset();
        command_reg_i = 8'h10; dreq_i = 4'b0011; hlda_i = 1;
        tick(3);
        hlda_i = 0; tick();
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL abort_hrq got=%b exp=0", hrq_o); end
        hlda_i = 1; tick();
        total++; if (valid_dreq_o !== 4'b0001) begin bad++; $display("FAIL abort_rotptr got=%b exp=0001", valid_dreq_o); end
        tick(); valid_dack_i = 1; #1;
        total++; if (dack_c_o !== 4'b1110) begin bad++; $display("FAIL abort_regrant_dack got=%b exp=1110", dack_c_o); end
        rst_ni = 0; #1;
        total++; if (hrq_o !== 1'b0 || dack_c_o !== 4'hF) begin bad++; $display("FAIL async_reset got=%b/%b exp=0/1111", hrq_o, dack_c_o); end
        tick(); rst_ni = 1;
    endtask

    task automatic test_sense_disable;
        clear_inputs();
        command_reg_i = 8'h40; dreq_i = 4'b1110;
        do_reset();
        tick(2);
        total++; if (valid_dreq_o !== 4'b0001) begin bad++; $display("FAIL sense_dreq got=%b exp=0001", valid_dreq_o); end
        command_reg_i = 8'hC0; hlda_i = 1;
        tick(); valid_dack_i = 1; #1;
        total++; if (dack_c_o !== 4'b0001) begin bad++; $display("FAIL sense_dack got=%b exp=0001", dack_c_o); end
        command_reg_i = 8'hC4; tick();
        total++; if (hrq_o !== 1'b1) begin bad++; $display("FAIL disable_midgrant got=%b exp=1", hrq_o); end
        xfer_done_i = 1; tick(); xfer_done_i = 0;
        tick(3);
        total++; if (hrq_o !== 1'b0) begin bad++; $display("FAIL disable_block got=%b exp=0", hrq_o); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rotating();
        test_mask_swreq();
        test_block();
        test_demand();
        test_abort_reset();
        test_sense_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

- Channel request arbiter for the 8237A-style DMA controller.
- Samples the four DREQ pins and the software request register, and applies mask, sense and disable controls.
- Picks one channel by fixed or rotating priority, drives HRQ to the CPU and holds the grant through the transfer sequence run by the timing control FSM.
- Drives DACK pins and a one-hot VALID_DREQ vector consumed by the timing control and the address/count datapath.

## Interface
- NCH, 4, number of channels; fixed at 4 for 8237A compatibility.
- CLK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DREQ  in  4  raw channel request pins.
- HLDA  in  1  hold acknowledge from CPU.
- commandReg  in  8  bit2 controller disable, bit4 rotating priority, bit6 DREQ sense (1 = active low), bit7 DACK sense (1 = active high).
- maskReg  in  4  per-channel mask, 1 = masked.
- requestReg  in  4  software request bits, honoured regardless of mask.
- modeReg  in  4x8  per-channel mode; [7:6] 00 demand, 01 single, 10 block, 11 cascade (treated as single).
- validDACK  in  1  timing FSM is in S1..S4 of a transfer.
- xferDone  in  1  one-cycle pulse at S4 completion.
- eopIn  in  1  internal or external end-of-process, active high.
- HRQ  out  1  hold request.
- DACK  out  4  channel acknowledge pins, polarity per commandReg[7].
- VALID_DREQ  out  4  one-hot granted channel, 0 when none.
- activeCh  out  2  encoded granted channel.

## Operation
- Effective request: `req[i] = (syncDreq[i] & ~maskReg[i]) | requestReg[i]`, where `syncDreq = DREQ ^ {4{commandReg[6]}}` registered once.
- States are ARB_IDLE, ARB_HOLD and ARB_GRANT.
- ARB_IDLE:
  - HRQ = 0, VALID_DREQ = 0.
  - If any req and commandReg[2] == 0: latch the winner into grantCh and go to ARB_HOLD.
- ARB_HOLD:
  - HRQ = 1 and VALID_DREQ = onehot(grantCh); the grant is frozen, so later higher-priority requests are ignored.
  - HLDA = 1 → ARB_GRANT.
  - Winning request drops before HLDA in demand mode → ARB_IDLE.
- ARB_GRANT:
  - HRQ = 1 and VALID_DREQ held.
  - DACK[grantCh] is active while validDACK = 1.
  - Release on xferDone:
    - single/cascade: always.
    - block: only if eopIn.
    - demand: if eopIn or req[grantCh] == 0.
  - Release means → ARB_IDLE, HRQ = 0 for at least one cycle.
- Priority selection:
  - Fixed mode (commandReg[4] == 0): channel 0 is highest, channel 3 lowest.
  - Rotating mode: search starts at rotPtr; on every release, rotPtr <= grantCh + 1 mod 4.
- HLDA deasserting in ARB_GRANT aborts the grant → ARB_IDLE; rotPtr is unchanged.
- Setting commandReg[2] mid-transfer does not abort the grant; it blocks only new arbitration.
- Simultaneous eopIn and xferDone count as a release in every mode.
- eopIn without xferDone is held pending until the next xferDone.

## Timing
- DREQ to req: 1 cycle (sync register).
- req to HRQ: registered, asserted the cycle after req is seen in ARB_IDLE, so 2 cycles from the pin.
- HLDA to DACK: DACK follows validDACK combinationally, gated by a registered state == ARB_GRANT.
- Reset values:
  - state ARB_IDLE, HRQ 0, VALID_DREQ 0, activeCh 0, rotPtr 0, syncDreq 0, eopPending 0.
  - DACK = all inactive: 4'hF when commandReg[7] = 0, 4'h0 when commandReg[7] = 1.
- Reset asserted mid-grant drops HRQ and DACK immediately (async).

## Configuration
- DMA_ROTATING_PRIORITY_EN
  - Defined: rotPtr register and rotating search are built; commandReg[4] selects the mode.
  - Undefined: rotPtr is absent, commandReg[4] is ignored and priority is always fixed 0 > 1 > 2 > 3.

## Structure
- DmaPackage holds:
  - the arbState_t enum (ARB_IDLE, ARB_HOLD, ARB_GRANT);
  - mode constants MODE_DEMAND, MODE_SINGLE, MODE_BLOCK, MODE_CASCADE;
  - command bit index constants CMD_DISABLE, CMD_ROTATE, CMD_DREQ_SENSE, CMD_DACK_SENSE.
- One combinational sub-module, dmaPriorityEncoder:
  - inputs req[3:0] and startPtr[1:0];
  - outputs hit and winner[1:0].

## Test plan
- Fixed priority:
  - DREQ = 4'b1010, mask 0, commandReg 0 → HRQ two cycles later.
  - HLDA = 1 → grant to channel 1: VALID_DREQ = 4'b0010, DACK = 4'b1101 while validDACK.
- Rotating priority:
  - commandReg[4] = 1, all DREQ held, single mode, four xferDone releases → grant order 0, 1, 2, 3; then ch0 again.
  - rotPtr returns to 0 after ch3.
- Mask and software request:
  - maskReg = 4'b0001, DREQ = 4'b0001 → no HRQ.
  - requestReg[0] = 1 → HRQ and grant to ch0.
- Block vs demand:
  - block ch2, xferDone without eopIn → grant kept; xferDone with eopIn → ARB_IDLE, HRQ low one cycle.
  - demand ch2, DREQ drops before xferDone → release on xferDone.
- Abort and reset:
  - HLDA dropped in ARB_GRANT → ARB_IDLE, rotPtr unchanged.
  - RESET_N low mid-grant → HRQ 0 and DACK inactive in the same cycle.
- Sense bits:
  - commandReg[6] = 1 with DREQ = 4'b1110 → request on ch0.
  - commandReg[7] = 1 → DACK = 4'b0001 during the ch0 grant.
